// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Groups every non-clock signal of the fetch unit: the redirect request from
// the EX-stage branch/jump controller, the hazard stall, the instruction
// memory handshake, the IF/ID fields and the flush/stall pipeline controls.
//
// modport master : the fetch unit itself (drives IMEM_READ/ADDRESS, IF/ID,
//                  FLUSH, STALL_OUT; samples redirect, stall and memory)
// modport slave  : the surrounding pipeline and instruction memory
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;
  logic        BRANCH_SEL;
  logic [31:0] B_PC;
  logic        HAZARD_STALL;
  logic        IMEM_BUSYWAIT;
  logic [31:0] IMEM_INSTR;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] PC;
  logic [31:0] PC_4;
  logic [31:0] INSTRUCTION;
  logic        IF_VALID;
  logic        FLUSH;
  logic        STALL_OUT;

  modport master (
    input  BRANCH_SEL, B_PC, HAZARD_STALL, IMEM_BUSYWAIT, IMEM_INSTR,
    output IMEM_READ, IMEM_ADDRESS, PC, PC_4, INSTRUCTION, IF_VALID,
           FLUSH, STALL_OUT
  );

  modport slave (
    output BRANCH_SEL, B_PC, HAZARD_STALL, IMEM_BUSYWAIT, IMEM_INSTR,
    input  IMEM_READ, IMEM_ADDRESS, PC, PC_4, INSTRUCTION, IF_VALID,
           FLUSH, STALL_OUT
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Owns the fetch PC, issues instruction-memory reads with a busy-wait
// handshake, loads the IF/ID register and handles branch/jump redirects.
//
// Ports:
//   CLK    : system clock, rising edge
//   RESET  : asynchronous active-low reset
//   bus    : pc_fetch_unit_if.master
//            BRANCH_SEL/B_PC   redirect request and target
//            HAZARD_STALL      hold fetch (load-use)
//            IMEM_BUSYWAIT     current read still outstanding
//            IMEM_INSTR        returned word (valid when not busy)
//            IMEM_READ         read request (FETCH and REDIR_WAIT)
//            IMEM_ADDRESS      fetch address = F_PC
//            PC/PC_4/INSTRUCTION/IF_VALID  IF/ID fields
//            FLUSH             combinational clear of IF/ID and ID/EX
//            STALL_OUT         combinational freeze of upstream registers
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             CLK,
  input  logic             RESET,
  pc_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    REDIR_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_4_q, pc_4_d;
  logic [31:0] instr_q, instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  // Redirect target word-aligned; the low bits are simply dropped.
  logic [31:0] b_tgt;
  logic [31:0] redir_tgt;

  assign b_tgt = bus.B_PC & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    f_pc_d     = f_pc_q;
    pc_d       = pc_q;
    pc_4_d     = pc_4_q;
    instr_d    = instr_q;
    if_valid_d = if_valid_q;
    redir_pc_d = redir_pc_q;
    redir_tgt  = redir_pc_q;

    case (state_q)
      IDLE: begin
        // Memory status is irrelevant here; no read is issued yet.
        state_d = FETCH;
      end

      FETCH: begin
        if (bus.BRANCH_SEL) begin
          instr_d    = NOP_INSTR;
          if_valid_d = 1'b0;
          if (!bus.IMEM_BUSYWAIT) begin
            f_pc_d = b_tgt;
          end else begin
            // Keep the address stable for the outstanding read and park
            // the target until memory finishes.
            redir_pc_d = b_tgt;
            state_d    = REDIR_WAIT;
          end
        end else if (!bus.IMEM_BUSYWAIT && !bus.HAZARD_STALL) begin
          instr_d    = bus.IMEM_INSTR;
          pc_d       = f_pc_q;
          pc_4_d     = f_pc_q + 32'd4;
          if_valid_d = 1'b1;
          f_pc_d     = f_pc_q + 32'd4;
        end
      end

      REDIR_WAIT: begin
        // A late redirect overrides the parked one (last target wins).
        if (bus.BRANCH_SEL) begin
          redir_pc_d = b_tgt;
          redir_tgt  = b_tgt;
        end
        // The word returned for the abandoned address is dropped.
        if (!bus.IMEM_BUSYWAIT) begin
          f_pc_d  = redir_tgt;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      f_pc_q     <= RESET_PC;
      pc_q       <= RESET_PC;
      pc_4_q     <= RESET_PC + 32'd4;
      instr_q    <= NOP_INSTR;
      if_valid_q <= 1'b0;
      redir_pc_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      f_pc_q     <= f_pc_d;
      pc_q       <= pc_d;
      pc_4_q     <= pc_4_d;
      instr_q    <= instr_d;
      if_valid_q <= if_valid_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign bus.IMEM_READ    = (state_q != IDLE);
  assign bus.IMEM_ADDRESS = f_pc_q;
  assign bus.PC           = pc_q;
  assign bus.PC_4         = pc_4_q;
  assign bus.INSTRUCTION  = instr_q;
  assign bus.IF_VALID     = if_valid_q;
  assign bus.FLUSH        = bus.BRANCH_SEL | (state_q == REDIR_WAIT);
  assign bus.STALL_OUT    = (state_q == FETCH) & bus.IMEM_BUSYWAIT & ~bus.BRANCH_SEL;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed scenarios with literal expectations, then randomized traffic.
// A flag-based model of the fetch unit is compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: running (left the post-reset idle cycle), pending redirect flag.
  logic        m_run;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic [31:0] m_fpc;
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run   <= 1'b0;
      m_pend  <= 1'b0;
      m_tgt   <= 32'h0;
      m_fpc   <= 32'h0;
      m_pc    <= 32'h0;
      m_pc4   <= 32'h4;
      m_instr <= NOP;
      m_valid <= 1'b0;
    end else if (!m_run) begin
      m_run <= 1'b1;
    end else if (m_pend) begin
      if (bus.BRANCH_SEL) m_tgt <= {bus.B_PC[31:2], 2'b00};
      if (!bus.IMEM_BUSYWAIT) begin
        m_fpc  <= bus.BRANCH_SEL ? {bus.B_PC[31:2], 2'b00} : m_tgt;
        m_pend <= 1'b0;
      end
    end else if (bus.BRANCH_SEL) begin
      m_instr <= NOP;
      m_valid <= 1'b0;
      if (bus.IMEM_BUSYWAIT) begin
        m_tgt  <= {bus.B_PC[31:2], 2'b00};
        m_pend <= 1'b1;
      end else begin
        m_fpc <= {bus.B_PC[31:2], 2'b00};
      end
    end else if (!bus.IMEM_BUSYWAIT && !bus.HAZARD_STALL) begin
      m_instr <= bus.IMEM_INSTR;
      m_pc    <= m_fpc;
      m_pc4   <= m_fpc + 32'd4;
      m_valid <= 1'b1;
      m_fpc   <= m_fpc + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_read",  {31'b0, bus.IMEM_READ}, {31'b0, m_run});
    chk("m_addr",  bus.IMEM_ADDRESS, m_fpc);
    chk("m_pc",    bus.PC, m_pc);
    chk("m_pc4",   bus.PC_4, m_pc4);
    chk("m_instr", bus.INSTRUCTION, m_instr);
    chk("m_valid", {31'b0, bus.IF_VALID}, {31'b0, m_valid});
    chk("m_flush", {31'b0, bus.FLUSH}, {31'b0, bus.BRANCH_SEL | m_pend});
    chk("m_stall", {31'b0, bus.STALL_OUT},
        {31'b0, m_run & ~m_pend & bus.IMEM_BUSYWAIT & ~bus.BRANCH_SEL});
  end

  task automatic apply(input logic br, input logic [31:0] bpc, input logic busy,
                       input logic hz, input logic [31:0] w);
    bus.BRANCH_SEL    = br;
    bus.B_PC          = bpc;
    bus.IMEM_BUSYWAIT = busy;
    bus.HAZARD_STALL  = hz;
    bus.IMEM_INSTR    = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'hA000_0000);
    repeat (3) tick();
    chk("rst_read",  {31'b0, bus.IMEM_READ}, 32'h0);
    chk("rst_instr", bus.INSTRUCTION, NOP);
    chk("rst_pc4",   bus.PC_4, 32'h4);

    // Reset release and sequential fetch.
    rst_n = 1'b1;
    #1;
    chk("idle_read", {31'b0, bus.IMEM_READ}, 32'h0);
    tick();
    chk("fetch_read", {31'b0, bus.IMEM_READ}, 32'h1);
    chk("addr0",      bus.IMEM_ADDRESS, 32'h0);
    tick();
    chk("addr4",  bus.IMEM_ADDRESS, 32'h4);
    chk("w0",     bus.INSTRUCTION, 32'hA000_0000);
    chk("w0_pc",  bus.PC, 32'h0);
    chk("w0_pc4", bus.PC_4, 32'h4);
    chk("w0_vld", {31'b0, bus.IF_VALID}, 32'h1);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'hA000_0001);
    tick();
    chk("addr8", bus.IMEM_ADDRESS, 32'h8);

    // Hazard stall for two cycles at F_PC=8.
    apply(1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0002);
    tick();
    chk("hz_addr1", bus.IMEM_ADDRESS, 32'h8);
    tick();
    chk("hz_addr2", bus.IMEM_ADDRESS, 32'h8);
    chk("hz_instr", bus.INSTRUCTION, 32'hA000_0001);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'hA000_0002);
    tick();
    chk("hz_resume",  bus.IMEM_ADDRESS, 32'hC);
    chk("hz_w2",      bus.INSTRUCTION, 32'hA000_0002);
    chk("hz_w2_pc",   bus.PC, 32'h8);

    // Redirect with memory ready, concurrent with a hazard stall.
    apply(1'b1, 32'h100, 1'b0, 1'b1, 32'hA000_0003);
    #1;
    chk("br_flush", {31'b0, bus.FLUSH}, 32'h1);
    tick();
    chk("br_addr",  bus.IMEM_ADDRESS, 32'h100);
    chk("br_instr", bus.INSTRUCTION, NOP);
    chk("br_valid", {31'b0, bus.IF_VALID}, 32'h0);

    // Redirect while memory is busy for three cycles.
    apply(1'b1, 32'h200, 1'b1, 1'b0, 32'hDEAD_BEEF);
    #1;
    chk("bw_flush0", {31'b0, bus.FLUSH}, 32'h1);
    chk("bw_stall0", {31'b0, bus.STALL_OUT}, 32'h0);
    tick();
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    for (int i = 1; i < 3; i++) begin
      #1;
      chk("bw_flush", {31'b0, bus.FLUSH}, 32'h1);
      chk("bw_stall", {31'b0, bus.STALL_OUT}, 32'h0);
      chk("bw_addr",  bus.IMEM_ADDRESS, 32'h100);
      tick();
    end
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    #1;
    chk("bw_flush3", {31'b0, bus.FLUSH}, 32'h1);
    tick();
    chk("bw_addr_tgt", bus.IMEM_ADDRESS, 32'h200);
    chk("bw_no_stale", bus.INSTRUCTION, NOP);
    chk("bw_flush_off", {31'b0, bus.FLUSH}, 32'h0);

    // Wrap-around and misaligned target.
    apply(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hA000_0004);
    tick();
    chk("wrap_tgt", bus.IMEM_ADDRESS, 32'hFFFF_FFFC);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'hA000_0004);
    tick();
    chk("wrap_addr", bus.IMEM_ADDRESS, 32'h0);
    chk("wrap_pc",   bus.PC, 32'hFFFF_FFFC);
    chk("wrap_pc4",  bus.PC_4, 32'h0);
    apply(1'b1, 32'h0000_0107, 1'b0, 1'b0, 32'hA000_0005);
    tick();
    chk("misalign", bus.IMEM_ADDRESS, 32'h104);

    // Asynchronous reset in the middle of a pending redirect.
    apply(1'b1, 32'h300, 1'b1, 1'b0, 32'hA000_0006);
    tick();
    apply(1'b0, 32'h0, 1'b1, 1'b0, 32'hA000_0006);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_addr",  bus.IMEM_ADDRESS, 32'h0);
    chk("ar_read",  {31'b0, bus.IMEM_READ}, 32'h0);
    chk("ar_flush", {31'b0, bus.FLUSH}, 32'h0);
    chk("ar_instr", bus.INSTRUCTION, NOP);
    chk("ar_pc4",   bus.PC_4, 32'h4);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'hA000_0007);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_restart", bus.IMEM_ADDRESS, 32'h0);
    tick();
    chk("ar_next", bus.IMEM_ADDRESS, 32'h4);

    // Randomized traffic, with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 9) == 0), $urandom,
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 6) == 0), $urandom);
      if (rst_n && $urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end
    rst_n = 1'b1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch end of the branch/jump redirect interface. Consumes BRANCH_SEL/B_PC from the EX-stage branch/jump controller and owns the fetch PC. Drives instruction-memory reads with a busy-wait handshake and loads the IF/ID fields. Generates the pipeline flush for redirects and the pipeline stall for instruction-memory waits.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) injected on flush

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset
BRANCH_SEL  input  1  redirect request from EX-stage branch/jump controller
B_PC  input  32  redirect target, valid when BRANCH_SEL=1
HAZARD_STALL  input  1  load-use stall from hazard unit; hold fetch
IMEM_BUSYWAIT  input  1  instruction memory not ready; current read outstanding
IMEM_INSTR  input  32  instruction word, valid when IMEM_BUSYWAIT=0
IMEM_READ  output  1  read request to instruction memory
IMEM_ADDRESS  output  32  fetch address (= F_PC)
PC  output  32  PC of instruction held in IF/ID
PC_4  output  32  PC+4 of that instruction
INSTRUCTION  output  32  IF/ID instruction
IF_VALID  output  1  IF/ID holds a real instruction
FLUSH  output  1  clear IF/ID and ID/EX (combinational)
STALL_OUT  output  1  freeze upstream pipeline registers (combinational)

Behaviour:
- Reset (RESET=0, async): state=IDLE, F_PC=RESET_PC, PC=RESET_PC, PC_4=RESET_PC+4, INSTRUCTION=NOP_INSTR, IF_VALID=0, IMEM_READ=0, REDIR_PC=0. Applies immediately, even mid-wait or mid-redirect; any outstanding read is abandoned.
- States: IDLE, FETCH, REDIR_WAIT.
- IDLE: IMEM_READ=0. First rising edge with RESET=1 -> FETCH. F_PC is unchanged.
- IMEM_READ=1 in FETCH and REDIR_WAIT. IMEM_ADDRESS=F_PC in every state.
- FETCH, evaluated per edge, priority highest first:
  1. BRANCH_SEL=1, IMEM_BUSYWAIT=0: F_PC<={B_PC[31:2],2'b00}; INSTRUCTION<=NOP_INSTR; IF_VALID<=0; PC/PC_4 hold; stay FETCH.
  2. BRANCH_SEL=1, IMEM_BUSYWAIT=1: REDIR_PC<={B_PC[31:2],2'b00}; F_PC holds so the address stays stable for memory; IF/ID<=bubble; -> REDIR_WAIT.
  3. IMEM_BUSYWAIT=1: all registers hold.
  4. HAZARD_STALL=1: all registers hold.
  5. Otherwise advance: INSTRUCTION<=IMEM_INSTR; PC<=F_PC; PC_4<=F_PC+4; IF_VALID<=1; F_PC<=F_PC+4.
- REDIR_WAIT: IF/ID holds the bubble.
  - IMEM_BUSYWAIT=1: hold.
  - IMEM_BUSYWAIT=0: the returned word is discarded; F_PC<=REDIR_PC; -> FETCH.
  - BRANCH_SEL=1 here (normally impossible, since downstream is flushed): REDIR_PC is overwritten; last target wins.
- FLUSH = BRANCH_SEL | (state==REDIR_WAIT).
- STALL_OUT = (state==FETCH) & IMEM_BUSYWAIT & ~BRANCH_SEL.
- Redirect has priority over HAZARD_STALL and IMEM_BUSYWAIT.
- Redirect latency: target appears on IMEM_ADDRESS one cycle after BRANCH_SEL when memory is ready. Otherwise it appears one cycle after IMEM_BUSYWAIT falls.
- Arithmetic: 32-bit unsigned with wrap-around; F_PC=32'hFFFF_FFFC advances to 32'h0000_0000. B_PC[1:0] are forced to 0, with no trap.
- IMEM_BUSYWAIT must be ignored in IDLE.

Test Plan:
- Reset release, IMEM_BUSYWAIT=0, instr words W0..W3: IMEM_READ rises one cycle after release. IMEM_ADDRESS steps 0,4,8,C per cycle. INSTRUCTION=W0 with PC=0, PC_4=4, IF_VALID=1 one edge after address 0.
- HAZARD_STALL=1 for 2 cycles at F_PC=8: IMEM_ADDRESS stays 8 for 2 cycles and IF/ID holds. Fetch resumes at 8 with no skipped or duplicated instruction.
- BRANCH_SEL=1, B_PC=32'h100, memory ready, same cycle as HAZARD_STALL=1: FLUSH=1 that cycle. Next cycle IMEM_ADDRESS=32'h100, INSTRUCTION=32'h13, IF_VALID=0.
- IMEM_BUSYWAIT=1 for 3 cycles, BRANCH_SEL=1 (B_PC=32'h200) in the first: IMEM_ADDRESS holds the old PC. FLUSH=1 for 4 cycles and STALL_OUT=0. One cycle after busy drops, IMEM_ADDRESS=32'h200 and the stale word never reaches INSTRUCTION.
- Wrap and misalignment: F_PC=32'hFFFF_FFFC advances to 0. BRANCH_SEL with B_PC=32'h0000_0107 loads 32'h104.
- RESET asserted mid-REDIR_WAIT: outputs return to reset values immediately without waiting for CLK. After release, fetch restarts at RESET_PC with REDIR_PC discarded.
